// File: rtl/jk_sync_counter.sv
// Synchronous modulo-MODULUS up/down counter built from one JK cell per bit.
// Next state comes only from per-bit J/K terms; q and wrap are registered, tc is combinational.
module jk_sync_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULUS - 1);
  localparam int unsigned      FULL_RANGE = 1 << WIDTH;

  logic [WIDTH-1:0] load_sat;
  logic [WIDTH-1:0] tog_up;
  logic [WIDTH-1:0] tog_dn;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             run_up;
  logic             run_dn;
  logic             at_max;
  logic             at_zero;
  logic             wrap_c;

  // Clamp the load value to the top of the count range; nothing to clamp at full binary range.
  if (MODULUS >= FULL_RANGE) begin : g_no_clamp
    assign load_sat = load_val;
  end else begin : g_clamp
    assign load_sat = (load_val > MAX_VAL) ? MAX_VAL : load_val;
  end

  // Out-of-range counts are folded into the terminal case when counting up.
  assign at_max  = (q >= MAX_VAL);
  assign at_zero = (q == '0);

  assign tc     = en & ((up & (q == MAX_VAL)) | (~up & at_zero));
  assign wrap_c = en & ~load & (up ? at_max : at_zero);

  // Ripple-free toggle masks: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    run_up = 1'b1;
    run_dn = 1'b1;
    tog_up = '0;
    tog_dn = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tog_up[i] = run_up;
      tog_dn[i] = run_dn;
      run_up    = run_up & q[i];
      run_dn    = run_dn & ~q[i];
    end
  end

  // J/K steering: load > count > hold.
  always_comb begin
    j = '0;
    k = '0;
    if (load) begin
      j = load_sat;
      k = ~load_sat;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          j = '0;
          k = '1;
        end else begin
          j = tog_up;
          k = tog_up;
        end
      end else begin
        if (at_zero) begin
          j = MAX_VAL;
          k = ~MAX_VAL;
        end else begin
          j = tog_dn;
          k = tog_dn;
        end
      end
    end
  end

  // JK cell bank plus the wrap pulse register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= (j & ~q) | (~k & q);
      wrap <= wrap_c;
    end
  end

endmodule

// File: tb/tb_jk_sync_counter.sv
// Bench for jk_sync_counter: a MODULUS=10 and a MODULUS=16 instance driven in parallel,
// checked every cycle against an arithmetic model plus directed literal expectations.
module tb_jk_sync_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up, load;
  logic [3:0] load_val;
  logic [3:0] q0, q1;
  logic       tc0, tc1, wrap0, wrap1;

  int  passed = 0;
  int  total  = 0;
  bit  checking = 1'b0;
  int  mods[2] = '{10, 16};
  int  m_q[2]  = '{0, 0};
  bit  m_wrap[2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .q(q0), .tc(tc0), .wrap(wrap0)
  );

  jk_sync_counter #(.WIDTH(4), .MODULUS(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .q(q1), .tc(tc1), .wrap(wrap1)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: count semantics in plain integer arithmetic.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_q[d] = 0;
        m_wrap[d] = 1'b0;
      end else if (load) begin
        m_q[d] = (int'(load_val) > mods[d] - 1) ? mods[d] - 1 : int'(load_val);
        m_wrap[d] = 1'b0;
      end else if (en && up) begin
        m_wrap[d] = (m_q[d] == mods[d] - 1);
        m_q[d] = m_wrap[d] ? 0 : m_q[d] + 1;
      end else if (en) begin
        m_wrap[d] = (m_q[d] == 0);
        m_q[d] = m_wrap[d] ? mods[d] - 1 : m_q[d] - 1;
      end else begin
        m_wrap[d] = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        int act_q, act_tc, act_wrap, exp_tc;
        act_q    = (d == 0) ? int'(q0) : int'(q1);
        act_tc   = (d == 0) ? int'(tc0) : int'(tc1);
        act_wrap = (d == 0) ? int'(wrap0) : int'(wrap1);
        exp_tc   = int'(en && (up ? (m_q[d] == mods[d] - 1) : (m_q[d] == 0)));
        chk($sformatf("model_q[%0d]", d), act_q, m_q[d]);
        chk($sformatf("model_wrap[%0d]", d), act_wrap, int'(m_wrap[d]));
        chk($sformatf("model_tc[%0d]", d), act_tc, exp_tc);
      end
    end
  end

  initial begin
    int exp2[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp3[3]  = '{9, 8, 7};
    int exp4[3]  = '{8, 9, 0};

    // 1: reset with every other input active
    rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd5;
    tick();
    tick();
    chk("rst_q0", int'(q0), 0);
    chk("rst_q1", int'(q1), 0);
    chk("rst_wrap0", int'(wrap0), 0);
    chk("rst_tc0", int'(tc0), 0);
    checking = 1'b1;

    // 2: count up through the modulus
    rst_n = 1'b1; load = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("up_q", int'(q0), exp2[i]);
      chk("up_wrap", int'(wrap0), (exp2[i] == 0 && i == 9) ? 1 : 0);
      chk("up_tc", int'(tc0), (exp2[i] == 9) ? 1 : 0);
    end

    // 3: reach 0, then count down through the wrap
    repeat (8) tick();
    chk("at_zero_q", int'(q0), 0);
    up = 1'b0;
    #1;
    chk("down_tc_zero", int'(tc0), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("down_q", int'(q0), exp3[i]);
      chk("down_wrap", int'(wrap0), (i == 0) ? 1 : 0);
    end

    // 4: load with en high, then count; then a clamped load
    load = 1'b1; load_val = 4'd7; up = 1'b1;
    tick();
    chk("load7_q", int'(q0), 7);
    chk("load7_wrap", int'(wrap0), 0);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("after_load_q", int'(q0), exp4[i]);
      chk("after_load_wrap", int'(wrap0), (i == 2) ? 1 : 0);
    end
    load = 1'b1; load_val = 4'd12;
    tick();
    chk("clamp_q0", int'(q0), 9);
    chk("clamp_q1", int'(q1), 12);
    chk("clamp_wrap", int'(wrap0), 0);

    // 5: hold at 4 while direction toggles
    load_val = 4'd4;
    tick();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up = ~up;
      tick();
      chk("hold_q", int'(q0), 4);
      chk("hold_tc", int'(tc0), 0);
      chk("hold_wrap", int'(wrap0), 0);
    end

    // 6: reset mid-count, then restart
    en = 1'b1; up = 1'b1;
    tick();
    tick();
    chk("pre_rst_q", int'(q0), 6);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_q", int'(q0), 0);
    chk("mid_rst_wrap", int'(wrap0), 0);
    rst_n = 1'b1;
    tick();
    chk("restart_q", int'(q0), 1);

    // Full binary range: 15 -> 0 wraps on the MODULUS=16 instance
    load = 1'b1; load_val = 4'd15;
    tick();
    chk("m16_load_q", int'(q1), 15);
    load = 1'b0;
    #1;
    chk("m16_tc", int'(tc1), 1);
    tick();
    chk("m16_wrap_q", int'(q1), 0);
    chk("m16_wrap", int'(wrap1), 1);
    chk("m10_wrap_q", int'(q0), 0);

    // Randomized phase against the model
    repeat (3000) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 9) < 7);
      up       = 1'($urandom_range(0, 1));
      load_val = 4'($urandom_range(0, 15));
      tick();
    end

    @(negedge clk);
    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
